// File: rtl/uart_frame_pkg.sv
// Shared types and width helpers for the UART receive framing controller.
// Frame on the wire: SYNC, LEN, LEN payload bytes, CK = (LEN + sum of payload) mod 256.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CKSUM   = 3'd3,
    ST_HOLD    = 3'd4
  } frame_state_e;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hA5;
  localparam int unsigned DEF_MAX_LEN        = 32'd16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd50000;

  function automatic int unsigned idx_width(input int unsigned max_len);
    return (max_len > 32'd1) ? $clog2(max_len) : 32'd1;
  endfunction

  // Length must also represent MAX_LEN itself, hence one extra bit.
  function automatic int unsigned len_width(input int unsigned max_len);
    return idx_width(max_len) + 32'd1;
  endfunction

  function automatic int unsigned tmo_width(input int unsigned cycles);
    return (cycles > 32'd2) ? $clog2(cycles) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_rx_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file, synchronous write, asynchronous read.
// Contents are intentionally not reset.
module uart_rx_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned IDX_W   = idx_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem_r [MAX_LEN];

  // payload write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framing controller: sync hunt, length-prefixed payload capture,
// checksum check, valid/ready frame hand-off. Optional counters: UART_RX_FRAME_STATS_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rxdata,
  input  logic                          rxdone,
  input  logic                          rxbusy,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [len_width(MAX_LEN)-1:0] frame_len,
  input  logic [idx_width(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                    rd_data,
  output logic                          ctrl_busy,
  output logic                          err_cksum,
  output logic                          err_len,
  output logic                          err_timeout,
  output logic                          err_overrun
`ifdef UART_RX_FRAME_STATS_EN
  ,
  output logic [15:0]                   frame_cnt,
  output logic [15:0]                   err_cnt
`endif
);

  localparam int unsigned IDX_W = idx_width(MAX_LEN);
  localparam int unsigned LEN_W = len_width(MAX_LEN);
  localparam int unsigned TMO_W = tmo_width(TIMEOUT_CYCLES);
  localparam logic [8:0]       MAX_LEN_9 = 9'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ZERO  = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO  = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  // The pulse is registered, so firing when the count sits one short lands it on TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 32'd2);

  frame_state_e     state_r, state_nxt_s;
  logic [LEN_W-1:0] len_r, len_nxt_s;
  logic [LEN_W-1:0] idx_r, idx_nxt_s;
  logic [7:0]       sum_r, sum_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic [LEN_W-1:0] flen_r, flen_nxt_s;
  logic             busy_r;
  logic             e_ck_r, e_len_r, e_tmo_r, e_ovr_r;
  logic             e_ck_s, e_len_s, e_tmo_s, e_ovr_s;
  logic             we_s;
  logic             is_sync_s;

  assign is_sync_s = rxdone && (rxdata == SYNC_BYTE);

  uart_rx_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (we_s),
    .waddr (idx_r[IDX_W-1:0]),
    .wdata (rxdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // state, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      len_r   <= LEN_ZERO;
      idx_r   <= LEN_ZERO;
      sum_r   <= 8'h00;
      tmo_r   <= TMO_ZERO;
      valid_r <= 1'b0;
      flen_r  <= LEN_ZERO;
      busy_r  <= 1'b0;
      e_ck_r  <= 1'b0;
      e_len_r <= 1'b0;
      e_tmo_r <= 1'b0;
      e_ovr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      len_r   <= len_nxt_s;
      idx_r   <= idx_nxt_s;
      sum_r   <= sum_nxt_s;
      tmo_r   <= tmo_nxt_s;
      valid_r <= valid_nxt_s;
      flen_r  <= flen_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      e_ck_r  <= e_ck_s;
      e_len_r <= e_len_s;
      e_tmo_r <= e_tmo_s;
      e_ovr_r <= e_ovr_s;
    end
  end

  // next-state and datapath decode
  always_comb begin
    state_nxt_s = state_r;
    len_nxt_s   = len_r;
    idx_nxt_s   = idx_r;
    sum_nxt_s   = sum_r;
    tmo_nxt_s   = TMO_ZERO;
    valid_nxt_s = valid_r;
    flen_nxt_s  = flen_r;
    we_s        = 1'b0;
    e_ck_s      = 1'b0;
    e_len_s     = 1'b0;
    e_tmo_s     = 1'b0;
    e_ovr_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (is_sync_s) begin
          state_nxt_s = ST_LEN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rxdone) begin
          len_nxt_s = LEN_W'(rxdata);
          sum_nxt_s = rxdata;
          idx_nxt_s = LEN_ZERO;
          if ({1'b0, rxdata} > MAX_LEN_9) begin
            e_len_s     = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (rxdata == 8'h00) begin
            state_nxt_s = ST_CKSUM;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      ST_PAYLOAD: begin
        if (rxdone) begin
          we_s      = 1'b1;
          sum_nxt_s = sum_r + rxdata;
          idx_nxt_s = idx_r + LEN_ONE;
          if ((idx_r + LEN_ONE) == len_r) begin
            state_nxt_s = ST_CKSUM;
          end else begin
            state_nxt_s = ST_PAYLOAD;
          end
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_CKSUM: begin
        if (rxdone && (rxdata == sum_r)) begin
          state_nxt_s = ST_HOLD;
          valid_nxt_s = 1'b1;
          flen_nxt_s  = len_r;
        end else if (rxdone) begin
          e_ck_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CKSUM;
        end
      end
      ST_HOLD: begin
        // A byte arriving with the release is treated as the first IDLE byte.
        if (frame_ready) begin
          valid_nxt_s = 1'b0;
          if (is_sync_s) begin
            state_nxt_s = ST_LEN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (rxdone) begin
          e_ovr_s = 1'b1;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase

    // RXDONE always beats an expiring timeout.
    if ((state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CKSUM)) begin
      if (rxdone) begin
        tmo_nxt_s = TMO_ZERO;
      end else if (rxbusy) begin
        tmo_nxt_s = tmo_r;
      end else if (tmo_r == TMO_LAST) begin
        e_tmo_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end else begin
        tmo_nxt_s = tmo_r + TMO_ONE;
      end
    end else begin
      tmo_nxt_s = TMO_ZERO;
    end
  end

  assign frame_valid = valid_r;
  assign frame_len   = flen_r;
  assign ctrl_busy   = busy_r;
  assign err_cksum   = e_ck_r;
  assign err_len     = e_len_r;
  assign err_timeout = e_tmo_r;
  assign err_overrun = e_ovr_r;

`ifdef UART_RX_FRAME_STATS_EN
  logic [15:0] frame_cnt_r, err_cnt_r;
  logic        valid_rise_s, err_any_s;

  assign valid_rise_s = valid_nxt_s && !valid_r;
  assign err_any_s    = e_ck_s || e_len_s || e_tmo_s || e_ovr_s;

  // saturating frame and error counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_r <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      if (valid_rise_s && (frame_cnt_r != 16'hFFFF)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (err_any_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;
`endif

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Framing controller that sequences the UART receive path.
- Consumes the byte stream (RXDATA / RXDONE / RXBUSY) from the RXD receiver.
- Hunts for a sync byte, then collects a length-prefixed payload into a local buffer and verifies the checksum.
- Presents each complete frame to downstream logic through a valid/ready handshake with a random-access read port, and reports framing errors.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, max payload bytes (power of 2, ≤256); buffer depth.
- TIMEOUT_CYCLES, 50_000, inter-byte timeout in CLK cycles (≥2).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RXDATA  in  8  received byte, valid when RXDONE=1.
- RXDONE  in  1  one-cycle strobe per received byte.
- RXBUSY  in  1  receiver mid-byte; holds the timeout counter.
- FRAME_VALID  out  1  complete, checksum-good frame held.
- FRAME_READY  in  1  consumer releases the frame.
- FRAME_LEN  out  $clog2(MAX_LEN)+1  payload length of held frame.
- RD_ADDR  in  $clog2(MAX_LEN)  payload byte index.
- RD_DATA  out  8  buffer[RD_ADDR], combinational.
- CTRL_BUSY  out  1  high in any state except IDLE.
- ERR_CKSUM  out  1  pulse: checksum mismatch.
- ERR_LEN  out  1  pulse: LEN byte > MAX_LEN.
- ERR_TIMEOUT  out  1  pulse: inter-byte timeout.
- ERR_OVERRUN  out  1  pulse: byte arrived while frame held.

Behaviour:
- Reset (RESET=0, async):
  - State IDLE.
  - All outputs 0 (FRAME_VALID, FRAME_LEN, CTRL_BUSY, all ERR_*).
  - Counters and checksum cleared.
  - Buffer contents not reset.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CK.
  - CK = (LEN + sum of payload) mod 256.
- IDLE:
  - RXDONE with RXDATA==SYNC_BYTE -> LEN.
  - Any other byte is discarded silently.
- LEN, on RXDONE:
  - LEN > MAX_LEN -> ERR_LEN pulse, go to IDLE.
  - LEN == 0 -> CKSUM.
  - Otherwise -> PAYLOAD.
  - In all cases: latch LEN, seed sum = LEN, index = 0.
- PAYLOAD, on RXDONE:
  - Write buffer[index], sum += byte, index++.
  - After byte LEN-1 -> CKSUM.
- CKSUM, on RXDONE:
  - Byte == sum[7:0] -> HOLD; FRAME_VALID=1 the cycle after this RXDONE (1-cycle latency); FRAME_LEN = LEN.
  - Mismatch -> ERR_CKSUM pulse, go to IDLE.
- HOLD:
  - FRAME_VALID stays high and FRAME_LEN stays stable.
  - FRAME_VALID && FRAME_READY -> FRAME_VALID=0 next cycle, go to IDLE.
  - RXDONE while in HOLD without FRAME_READY: byte dropped, buffer untouched, ERR_OVERRUN pulse, stay in HOLD.
  - RXDONE and FRAME_READY in the same cycle: handshake completes, and the byte is evaluated as an IDLE byte (a SYNC_BYTE goes directly to LEN). No ERR_OVERRUN.
- Timeout (LEN, PAYLOAD, CKSUM only):
  - Counter clears on RXDONE and holds while RXBUSY=1; otherwise increments.
  - Reaching TIMEOUT_CYCLES-1 -> ERR_TIMEOUT pulse, go to IDLE.
  - If RXDONE arrives in the same cycle as the timeout, RXDONE wins.
- Error pulses: exactly one cycle each; at most one per cycle.
- RD_DATA:
  - Meaningful only while FRAME_VALID=1 and RD_ADDR < FRAME_LEN.
  - All other cases are don't-care.
- Mid-frame reset: frame is abandoned, and the next frame requires a fresh SYNC_BYTE.

Optional Feature:
- Macro: UART_RX_FRAME_STATS_EN.
- Defined:
  - Adds outputs FRAME_CNT[15:0] and ERR_CNT[15:0], both saturating at 16'hFFFF and reset to 0.
  - FRAME_CNT increments on each FRAME_VALID rising edge.
  - ERR_CNT increments on any ERR_* pulse.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package uart_frame_pkg:
  - state encoding: IDLE, LEN, PAYLOAD, CKSUM, HOLD.
  - default SYNC_BYTE 8'hA5.
  - width helper constants for index and length.
- Sub-module uart_rx_frame_buf:
  - MAX_LEN x 8 register file.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port.
- All control stays in the top module.

Test Plan:
- Good frame: A5 03 11 22 33 69 -> FRAME_VALID 1 cycle after the last RXDONE; FRAME_LEN=3; RD_ADDR 0/1/2 -> 11/22/33. FRAME_READY pulse -> FRAME_VALID=0 next cycle, CTRL_BUSY=0.
- Bad checksum: A5 02 01 02 00 -> single ERR_CKSUM pulse, FRAME_VALID stays 0, state IDLE. A following good frame A5 01 7F 80 is accepted.
- Length cases:
  - A5 11 with MAX_LEN=16 -> ERR_LEN pulse, return to IDLE.
  - A5 00 00 -> frame valid with FRAME_LEN=0.
  - Leading garbage 00 FF before A5 is ignored.
- Timeout: A5 02 11, then idle (RXBUSY=0) for TIMEOUT_CYCLES=100 -> ERR_TIMEOUT exactly once at cycle 99 after the last RXDONE. A later A5 01 05 06 is accepted.
- Overrun: hold a frame with FRAME_READY=0 and send byte 42 -> ERR_OVERRUN pulse, RD_DATA unchanged. Then assert FRAME_READY in the same cycle as RXDONE(A5) -> release, and the controller enters LEN.
- Reset mid-PAYLOAD (after A5 04 01) -> all outputs 0 immediately (asynchronous). The subsequent byte stream 04 ... with no sync is ignored.
